// File: rtl/dll_tx_arbiter.sv
// Data-link transmit arbiter: Ack/Nak, UpdateFC and TLP onto one frame slot.
// Starvation and UpdateFC-urgency overrides sit on top of the fixed priority.
module dll_tx_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int FC_TIMER     = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ack_req_i,
    input  logic [47:0]   ack_dllp_i,
    input  logic          fc_req_i,
    input  logic [47:0]   fc_dllp_i,
    input  logic          tlp_req_i,
    input  logic [1195:0] tlp_frame_i,
    input  logic          tx_ready_i,
    output logic          ack_gnt_o,
    output logic          fc_gnt_o,
    output logic          tlp_gnt_o,
    output logic [1195:0] tx_data_o,
    output logic          tx_valid_o,
    output logic          tx_is_dllp_o,
    output logic          fc_urgent_o
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(FC_TIMER);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] FC_MAX     = TW'(FC_TIMER - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] fc_timer;
    logic          slot_free;
    logic          any_gnt;
    logic          dllp_gnt;

    assign fc_urgent_o = (fc_timer == FC_MAX);
    assign tx_valid_o  = (state_q == SEND);

    always_comb begin
        ack_gnt_o = 1'b0;
        fc_gnt_o  = 1'b0;
        tlp_gnt_o = 1'b0;
        state_d   = state_q;
        slot_free = (state_q == IDLE) || tx_ready_i;
        if (rst_n && slot_free) begin
            if (starve_cnt == STARVE_MAX && tlp_req_i)
                tlp_gnt_o = 1'b1;
            else if (fc_urgent_o && fc_req_i)
                fc_gnt_o = 1'b1;
            else if (ack_req_i)
                ack_gnt_o = 1'b1;
            else if (fc_req_i)
                fc_gnt_o = 1'b1;
            else if (tlp_req_i)
                tlp_gnt_o = 1'b1;
        end
        dllp_gnt = ack_gnt_o || fc_gnt_o;
        any_gnt  = dllp_gnt || tlp_gnt_o;
        unique case (state_q)
            IDLE: if (any_gnt) state_d = SEND;
            SEND: if (tx_ready_i && !any_gnt) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame register loads on any grant, otherwise holds under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_data_o    <= '0;
            tx_is_dllp_o <= 1'b0;
        end else if (tlp_gnt_o) begin
            tx_data_o    <= tlp_frame_i;
            tx_is_dllp_o <= 1'b0;
        end else if (ack_gnt_o) begin
            tx_data_o    <= {1148'd0, ack_dllp_i};
            tx_is_dllp_o <= 1'b1;
        end else if (fc_gnt_o) begin
            tx_data_o    <= {1148'd0, fc_dllp_i};
            tx_is_dllp_o <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (tlp_gnt_o) begin
            starve_cnt <= '0;
        end else if (dllp_gnt) begin
            if (!tlp_req_i)
                starve_cnt <= '0;
            else if (starve_cnt != STARVE_MAX)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // A grant clears the timer even on the cycle it would saturate.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fc_timer <= '0;
        end else if (fc_gnt_o) begin
            fc_timer <= '0;
        end else if (fc_timer != FC_MAX) begin
            fc_timer <= fc_timer + 1'b1;
        end
    end

endmodule

// File: doc/dll_tx_arbiter.md
DLL_TX_ARBITER -- requirements
Module: dll_tx_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive DLLP grants allowed while a TLP is pending.
REQ-002 Parameter FC_TIMER, default 1024: cycles without an UpdateFC grant before UpdateFC becomes urgent.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 ack_req_i  input  1  Ack/Nak DLLP request; held with data until granted.
REQ-006 ack_dllp_i  input  48  Ack/Nak DLLP including CRC.
REQ-007 fc_req_i  input  1  UpdateFC DLLP request; held with data until granted.
REQ-008 fc_dllp_i  input  48  UpdateFC DLLP including CRC.
REQ-009 tlp_req_i  input  1  framed TLP request; held with data until granted.
REQ-010 tlp_frame_i  input  1196  TLP framed as {seq[11:0], TLP[1151:0], LCRC[31:0]}.
REQ-011 tx_ready_i  input  1  downstream accepts tx_data_o this cycle.
REQ-012 ack_gnt_o / fc_gnt_o / tlp_gnt_o  output  1 each  one-cycle grant; requester drops or advances its request after it.
REQ-013 tx_data_o  output  1196  registered outgoing frame.
REQ-014 tx_valid_o  output  1  tx_data_o valid.
REQ-015 tx_is_dllp_o  output  1  current frame is a DLLP.
REQ-016 fc_urgent_o  output  1  UpdateFC timer expired.

Function
REQ-017 Slot free = !tx_valid_o || tx_ready_i; grants are issued only in a slot-free cycle, with at most one grant per cycle.
REQ-018 Grants are combinational from the current requests and registered state, and the granted data is captured at the same rising edge.
REQ-019 tx_valid_o rises on the edge after the grant, so grant-to-valid latency is 1 cycle.
REQ-020 While tx_valid_o=1 and tx_ready_i=0, tx_data_o, tx_is_dllp_o and tx_valid_o hold stable (SEND state).
REQ-021 If tx_ready_i=1 with no grant in that cycle, tx_valid_o falls on the next edge (IDLE state).
REQ-022 Back-to-back: tx_ready_i=1 plus a new grant in the same cycle reloads tx_data_o with no bubble.
REQ-023 FSM states: IDLE (tx_valid_o=0) and SEND (tx_valid_o=1).
REQ-024 IDLE->SEND on any grant; SEND->SEND on ready plus grant, or on !ready; SEND->IDLE on ready with no grant.
REQ-025 Base priority: ack > fc > tlp.
REQ-026 Override 1: fc_urgent_o=1 and fc_req_i=1 puts fc ahead of ack.
REQ-027 Override 2: starve_cnt==STARVE_LIMIT and tlp_req_i=1 puts tlp first, ahead of both DLLPs including urgent fc.
REQ-028 DLLP formatting: tx_data_o = {1148'd0, dllp[47:0]} with tx_is_dllp_o=1.
REQ-029 TLP formatting: tx_data_o = tlp_frame_i unmodified with tx_is_dllp_o=0.
REQ-030 starve_cnt increments on a DLLP grant while tlp_req_i=1, saturating at STARVE_LIMIT.
REQ-031 starve_cnt clears on a TLP grant, and on any DLLP grant while tlp_req_i=0.
REQ-032 fc_timer increments every cycle and saturates at FC_TIMER-1; fc_urgent_o = (fc_timer==FC_TIMER-1).
REQ-033 An fc grant clears fc_timer to 0 on the same edge, which also drops fc_urgent_o.
REQ-034 Simultaneous fc grant and timer expiry in one cycle: the clear wins.
REQ-035 Counter widths are $clog2(STARVE_LIMIT+1) and $clog2(FC_TIMER); no wrap-around occurs.
REQ-036 With no requests in a slot-free cycle, all grants stay 0 and counters other than fc_timer hold.

Reset
REQ-037 rst_n=0 at a clock edge: tx_valid_o=0, tx_data_o=0, tx_is_dllp_o=0, fc_urgent_o=0, starve_cnt=0, fc_timer=0, FSM=IDLE.
REQ-038 While rst_n=0, all grants are 0 regardless of requests.
REQ-039 Reset asserted mid-SEND drops the frame: no valid output on the first cycle after rst_n returns to 1.

Verification
REQ-040 Single TLP: tlp_req_i=1 with tlp_frame_i={12'd1, all-ones, 32'hDEADBEEF} and tx_ready_i=1 -> tlp_gnt_o=1 for 1 cycle, then tx_valid_o=1 with that exact frame and tx_is_dllp_o=0.
REQ-041 Priority: ack, fc and tlp requested together with ack_dllp_i=48'hBEEF_8A00_5511 -> grant order ack, fc, tlp on 3 consecutive cycles; tx_data_o low 48 bits = 48'hBEEF_8A00_5511 and upper bits 0 on the first frame.
REQ-042 Backpressure: tx_ready_i=0 for 5 cycles after a grant -> tx_data_o stable and no further grant for those 5 cycles; on the cycle tx_ready_i=1 the next grant fires.
REQ-043 Starvation: ack and fc held continuously with tlp_req_i=1 and STARVE_LIMIT=4 -> exactly 4 DLLP grants, then tlp_gnt_o, then starve_cnt=0.
REQ-044 FC timer: FC_TIMER=16, ack held continuously, fc_req_i raised at cycle 3 -> fc_urgent_o=1 at cycle 15 and fc_gnt_o beats ack at cycle 15; fc_urgent_o=0 on the next cycle.
REQ-045 Reset in flight: rst_n=0 while tx_valid_o=1 and tx_ready_i=0 -> tx_valid_o=0, tx_data_o=0 and fc_urgent_o=0 on the next cycle.
